// File: rtl/peak_bin_detect.sv
// peak_bin_detect: scans bins BIN_LO..BIN_HI of FFT RAM 1 after each frame,
// computes real^2+imag^2 for every bin and reports the bin with the largest
// power. It then holds that bin on rdaddr1 so the beam-weighting stage can
// read it. A new frame is taken only after that stage reports weightdone.
// Optional build macro: PEAK_THRESH_EN adds the thresh input and the
// nodetect output. A scan whose peak is below thresh ends in nodetect and
// returns to IDLE instead of raising detectdone.
module peak_bin_detect #(
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 511
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fftdone,
  input  logic        weightdone,
  input  logic [27:0] ramq1,
`ifdef PEAK_THRESH_EN
  input  logic [27:0] thresh,
  output logic        nodetect,
`endif
  output logic [9:0]  rdaddr1,
  output logic [9:0]  maxbin,
  output logic [27:0] maxpwr,
  output logic        detectdone,
  output logic        busy
);

  localparam int DATA_W = 14;
  localparam int PWR_W  = 2 * DATA_W;
  localparam logic [9:0] ADDR_LO = 10'(BIN_LO);
  localparam logic [9:0] ADDR_HI = 10'(BIN_HI);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  // Power of one RAM word. The full-width signed squares cannot overflow:
  // the largest square is (-8192)^2 = 2^26, so the sum is below 2^28.
  function automatic logic [PWR_W-1:0] pwr_calc(input logic [PWR_W-1:0] word);
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
    logic signed [PWR_W-1:0]  re_sq;
    logic signed [PWR_W-1:0]  im_sq;
    re    = word[PWR_W-1:DATA_W];
    im    = word[DATA_W-1:0];
    re_sq = PWR_W'(re) * PWR_W'(re);
    im_sq = PWR_W'(im) * PWR_W'(im);
    return $unsigned(re_sq) + $unsigned(im_sq);
  endfunction

  state_t            state_q, state_d;
  logic [9:0]        addr_q, addr_d;
  logic              wbseen_q, wbseen_d;
  logic [9:0]        maxbin_q, maxbin_d;
  logic [PWR_W-1:0]  maxpwr_q, maxpwr_d;
  logic              detectdone_q, detectdone_d;
  logic              nodetect_q, nodetect_d;
  logic              start;
  logic              upd;

  // Tag pipeline. Each address carries a valid tag, its bin index, and a
  // last-bin marker until its power reaches the compare stage.
  logic              vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
  logic              vld_p2_q, vld_p2_d, last_p2_q, last_p2_d;
  logic              vld_p3_q, vld_p3_d, last_p3_q, last_p3_d;
  logic [9:0]        bin_p1_q, bin_p1_d, bin_p2_q, bin_p2_d, bin_p3_q, bin_p3_d;
  logic [PWR_W-1:0]  pwr_p3_q, pwr_p3_d;

  // Pipeline next values: p1/p2 track the 2-cycle RAM latency, and p3
  // registers the power as the RAM data arrives.
  always_comb begin
    // stage p1: address presented last cycle, RAM access in flight
    vld_p1_d  = (state_q == SCAN);
    last_p1_d = (state_q == SCAN) && (addr_q == ADDR_HI);
    bin_p1_d  = addr_q;
    // stage p2: ramq1 holds this bin's data
    vld_p2_d  = vld_p1_q;
    last_p2_d = last_p1_q;
    bin_p2_d  = bin_p1_q;
    // stage p3: registered power, compared against the running maximum
    vld_p3_d  = vld_p2_q;
    last_p3_d = last_p2_q;
    bin_p3_d  = bin_p2_q;
    pwr_p3_d  = pwr_calc(ramq1);
  end

  // A bin wins only on strictly greater power. Bins arrive in ascending
  // order, so a tie keeps the lower bin.
  assign upd = vld_p3_q && (pwr_p3_q > maxpwr_q);

  // FSM next state, scan address, running maximum and completion pulses
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wbseen_d     = wbseen_q;
    maxbin_d     = maxbin_q;
    maxpwr_d     = maxpwr_q;
    detectdone_d = 1'b0;
    nodetect_d   = 1'b0;
    start        = 1'b0;

    if (upd) begin
      maxbin_d = bin_p3_q;
      maxpwr_d = pwr_p3_q;
    end

    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (fftdone) start = 1'b1;
      end
      SCAN: begin
        if (addr_q == ADDR_HI) state_d = DRAIN;
        else                   addr_d  = addr_q + 10'd1;
      end
      DRAIN: begin
        // The final compare happens this cycle, so maxpwr_d is the frame's peak.
        if (last_p3_q) begin
`ifdef PEAK_THRESH_EN
          if (maxpwr_d < thresh) begin
            nodetect_d = 1'b1;
            state_d    = IDLE;
            addr_d     = '0;
          end else begin
            detectdone_d = 1'b1;
            state_d      = DONE;
          end
`else
          detectdone_d = 1'b1;
          state_d      = DONE;
`endif
        end
      end
      DONE: begin
        if (weightdone) wbseen_d = 1'b1;
        if (fftdone && (wbseen_q || weightdone)) start = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d  = SCAN;
      addr_d   = ADDR_LO;
      maxbin_d = ADDR_LO;
      maxpwr_d = '0;
      wbseen_d = 1'b0;
    end
  end

  // Control and result registers; reset abandons any scan in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wbseen_q     <= 1'b0;
      maxbin_q     <= '0;
      maxpwr_q     <= '0;
      detectdone_q <= 1'b0;
      nodetect_q   <= 1'b0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      vld_p3_q     <= 1'b0;
      last_p1_q    <= 1'b0;
      last_p2_q    <= 1'b0;
      last_p3_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wbseen_q     <= wbseen_d;
      maxbin_q     <= maxbin_d;
      maxpwr_q     <= maxpwr_d;
      detectdone_q <= detectdone_d;
      nodetect_q   <= nodetect_d;
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      vld_p3_q     <= vld_p3_d;
      last_p1_q    <= last_p1_d;
      last_p2_q    <= last_p2_d;
      last_p3_q    <= last_p3_d;
    end
  end

  // Data side of the pipeline; the valid tags qualify it, so it needs no reset.
  always_ff @(posedge clk) begin
    bin_p1_q <= bin_p1_d;
    bin_p2_q <= bin_p2_d;
    bin_p3_q <= bin_p3_d;
    pwr_p3_q <= pwr_p3_d;
  end

  assign rdaddr1    = (state_q == DONE) ? maxbin_q : addr_q;
  assign maxbin     = maxbin_q;
  assign maxpwr     = maxpwr_q;
  assign detectdone = detectdone_q;
  assign busy       = (state_q == SCAN) || (state_q == DRAIN);
`ifdef PEAK_THRESH_EN
  assign nodetect   = nodetect_q;
`else
  logic unused_nodetect;
  assign unused_nodetect = nodetect_q;
`endif

endmodule

// File: doc/peak_bin_detect.md
PEAK_BIN_DETECT -- requirements
Module: peak_bin_detect

Interface
REQ-001 SHALL have parameter BIN_LO, default 1, first FFT bin scanned (DC excluded).
REQ-002 SHALL have parameter BIN_HI, default 511, last FFT bin scanned (positive half of 1024-pt FFT); BIN_LO <= BIN_HI <= 1023.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high; clock clk.
REQ-005 SHALL have port fftdone  input  1  one-cycle pulse: FFT RAM 1 holds a new frame.
REQ-006 SHALL have port weightdone  input  1  one-cycle pulse from the downstream beam-weighting stage: beam search finished.
REQ-007 SHALL have port ramq1  input  28  FFT RAM 1 read data: [27:14] signed real, [13:0] signed imag.
REQ-008 SHALL have port rdaddr1  output  10  FFT RAM 1 read address.
REQ-009 SHALL have port maxbin  output  10  bin index of the peak power.
REQ-010 SHALL have port maxpwr  output  28  peak power, real^2+imag^2, unsigned.
REQ-011 SHALL have port detectdone  output  1  one-cycle pulse: maxbin/maxpwr valid.
REQ-012 SHALL have port busy  output  1  high in SCAN and DRAIN.

Function
REQ-013 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-014 IDLE: fftdone sampled high (cycle 0) SHALL enter SCAN; max registers cleared (maxpwr=0, maxbin=BIN_LO).
REQ-015 SCAN: rdaddr1 SHALL present BIN_LO in cycle 1 and increment by one per cycle, reaching BIN_HI in cycle N, N=BIN_HI-BIN_LO+1; then DRAIN.
REQ-016 RAM read latency is 2 cycles: ramq1 for the address presented in cycle k is valid in cycle k+2.
REQ-017 Power SHALL be computed as real^2+imag^2 with signed 14x14 products, full 28-bit unsigned sum, no saturation; -8192 squared is valid (2^26).
REQ-018 Power SHALL be registered one cycle after ramq1 valid; compare/update one cycle later.
REQ-019 Update SHALL occur only on strictly greater power: ties keep the lowest bin; an all-zero frame yields maxbin=BIN_LO, maxpwr=0.
REQ-020 A valid-tag pipeline SHALL qualify compares; no stale or out-of-range data compared.
REQ-021 detectdone SHALL pulse for exactly one cycle in cycle N+4; state becomes DONE the same cycle.
REQ-022 maxbin and maxpwr SHALL hold stable from detectdone until the next accepted fftdone.
REQ-023 In DONE, rdaddr1 SHALL equal maxbin (downstream reads bin maxbin from RAM 1 via this address); in IDLE rdaddr1 SHALL be 0.
REQ-024 fftdone SHALL be ignored in SCAN and DRAIN (no restart, no queueing).
REQ-025 DONE: a wbseen flag SHALL set on weightdone; fftdone SHALL be accepted (back to SCAN, wbseen cleared) only when wbseen is set or weightdone is high the same cycle.
REQ-026 fftdone in DONE without wbseen/weightdone SHALL be dropped.
REQ-027 weightdone outside DONE SHALL be ignored.

Reset
REQ-028 On reset: state IDLE, rdaddr1=0, maxbin=0, maxpwr=0, detectdone=0, busy=0, wbseen=0, pipeline valids cleared.
REQ-029 Reset mid-SCAN/DRAIN SHALL abandon the scan with no detectdone; reset SHALL take priority over fftdone in the same cycle.

Configuration
REQ-030 Macro PEAK_THRESH_EN, when defined, SHALL add input thresh (28, unsigned) and output nodetect (1).
REQ-031 With PEAK_THRESH_EN, if final maxpwr < thresh at cycle N+4, nodetect SHALL pulse one cycle instead of detectdone and state SHALL return to IDLE; maxbin/maxpwr still updated.
REQ-032 Without PEAK_THRESH_EN, thresh/nodetect SHALL not exist and every scan SHALL end in detectdone.

Verification
REQ-033 Single tone: bin 100 = (1000,0), all others (10,10); fftdone -> detectdone at cycle 515, maxbin=100, maxpwr=1000000, rdaddr1=100 in DONE.
REQ-034 Tie and extremes: bins 7 and 300 = (-8192,-8192), others 0 -> maxbin=7, maxpwr=134217728; all-zero frame -> maxbin=1, maxpwr=0.
REQ-035 Handshake: fftdone in DONE before weightdone -> dropped; weightdone then fftdone -> new scan; weightdone and fftdone same cycle -> accepted; fftdone in SCAN -> ignored, single detectdone.
REQ-036 Reset at cycle 200 of SCAN -> all outputs 0, no detectdone; next fftdone scans normally.
REQ-037 PEAK_THRESH_EN, thresh=5000: peak power 4999 -> nodetect pulse, state IDLE; peak 5000 -> detectdone.
